// File: rtl/online_ctrl_pkg.sv
// Shared definitions for trigger-driven online-arithmetic sequencers.
// Provides the 2-bit FSM state encodings, default operand geometry and a
// width helper so derived counter/index widths never collapse to zero.
package online_ctrl_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_DONE     = 2'd2;
  localparam logic [1:0] ST_WAIT_LOW = 2'd3;

  localparam int unsigned DEF_NUM_DIGITS   = 16;
  localparam int unsigned DEF_ONLINE_DELAY = 3;

  // ceil(log2(n)), floored at 1 bit
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DEF_IDX_W = width_of(DEF_NUM_DIGITS);

endpackage

// File: rtl/online_op_sequencer_if.sv
// Control bundle between the trigger sequencer and the online operator.
//   sync_in, abort_req          : trigger level and cancel request (into sequencer)
//   op_start, op_done           : operation framing pulses
//   digit_in_valid, in_idx      : input-digit strobe and MSD-first index
//   digit_out_valid, out_idx    : output-digit strobe and index
//   busy, overrun               : activity flag and sticky re-trigger flag
// master = sequencer side, slave = operator/trigger side.
interface online_op_sequencer_if
  import online_ctrl_pkg::*;
#(
  parameter int unsigned IDX_W = DEF_IDX_W
);

  logic             sync_in;
  logic             abort_req;
  logic             op_start;
  logic             digit_in_valid;
  logic [IDX_W-1:0] in_idx;
  logic             digit_out_valid;
  logic [IDX_W-1:0] out_idx;
  logic             op_done;
  logic             busy;
  logic             overrun;

  modport master (
    input  sync_in, abort_req,
    output op_start, digit_in_valid, in_idx, digit_out_valid, out_idx,
           op_done, busy, overrun
  );

  modport slave (
    output sync_in, abort_req,
    input  op_start, digit_in_valid, in_idx, digit_out_valid, out_idx,
           op_done, busy, overrun
  );

endinterface

// File: rtl/rise_edge_detect.sv
// Rising-edge detector for an already-synchronised level.
//   clk, reset : clock and synchronous active-high reset
//   d          : input level
//   rise       : d high this cycle and low the previous cycle (combinational)
module rise_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_q;

  // previous-cycle level, updated every cycle regardless of consumer state
  always_ff @(posedge clk) begin
    if (reset) d_q <= 1'b0;
    else       d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/online_op_sequencer.sv
// Turns each rising edge of a synchronised trigger into one framed
// digit-serial online operation: op_start, NUM_DIGITS input-digit strobes,
// output-digit strobes lagging by ONLINE_DELAY, then op_done.
//   clk, reset : clock and synchronous active-high reset
//   bus        : master side of online_op_sequencer_if (all outputs registered)
module online_op_sequencer
  import online_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int unsigned ONLINE_DELAY = DEF_ONLINE_DELAY
) (
  input  logic                  clk,
  input  logic                  reset,
  online_op_sequencer_if.master bus
);

  localparam int unsigned CNT_W = width_of(NUM_DIGITS + ONLINE_DELAY);
  localparam int unsigned CNT_X = CNT_W + 1;
  localparam int unsigned IDX_W = width_of(NUM_DIGITS);

  localparam logic [CNT_W-1:0] CYC_LAST  = CNT_W'(NUM_DIGITS + ONLINE_DELAY - 1);
  // one extra bit so NUM_DIGITS == 2**CNT_W and the delay subtraction stay exact
  localparam logic [CNT_X-1:0] NUM_X     = CNT_X'(NUM_DIGITS);
  localparam logic [CNT_X-1:0] DELAY_X   = CNT_X'(ONLINE_DELAY);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic             overrun_q, overrun_d;
  logic             rise;

  logic             run_d;
  logic [CNT_X-1:0] cyc_x;
  logic [CNT_X-1:0] out_off;
  logic             op_start_d;
  logic             in_valid_d;
  logic [IDX_W-1:0] in_idx_d;
  logic             out_valid_d;
  logic [IDX_W-1:0] out_idx_d;
  logic             done_d;
  logic             busy_d;

  rise_edge_detect u_rise (
    .clk   (clk),
    .reset (reset),
    .d     (bus.sync_in),
    .rise  (rise)
  );

  // next state, counter, sticky flag and next-cycle output values
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    overrun_d = overrun_q;

    if (bus.abort_req) begin
      state_d = ST_IDLE;
      cyc_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_d = ST_RUN;
            cyc_d   = '0;
          end
        end
        ST_RUN: begin
          if (rise) overrun_d = 1'b1;
          if (cyc_q == CYC_LAST) begin
            state_d = ST_DONE;
            cyc_d   = '0;
          end else begin
            cyc_d = cyc_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (rise) overrun_d = 1'b1;
          state_d = bus.sync_in ? ST_WAIT_LOW : ST_IDLE;
        end
        ST_WAIT_LOW: begin
          if (!bus.sync_in) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // outputs are decoded from the next state so the registers line up with it
    run_d       = (state_d == ST_RUN);
    cyc_x       = {1'b0, cyc_d};
    out_off     = cyc_x - DELAY_X;
    op_start_d  = run_d && (cyc_d == '0);
    in_valid_d  = run_d && (cyc_x < NUM_X);
    in_idx_d    = in_valid_d ? IDX_W'(cyc_d) : '0;
    out_valid_d = run_d && !out_off[CNT_X-1];
    out_idx_d   = out_valid_d ? IDX_W'(out_off) : '0;
    done_d      = (state_d == ST_DONE);
    busy_d      = run_d || done_d;
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q             <= ST_IDLE;
      cyc_q               <= '0;
      overrun_q           <= 1'b0;
      bus.op_start        <= 1'b0;
      bus.digit_in_valid  <= 1'b0;
      bus.in_idx          <= '0;
      bus.digit_out_valid <= 1'b0;
      bus.out_idx         <= '0;
      bus.op_done         <= 1'b0;
      bus.busy            <= 1'b0;
    end else begin
      state_q             <= state_d;
      cyc_q               <= cyc_d;
      overrun_q           <= overrun_d;
      bus.op_start        <= op_start_d;
      bus.digit_in_valid  <= in_valid_d;
      bus.in_idx          <= in_idx_d;
      bus.digit_out_valid <= out_valid_d;
      bus.out_idx         <= out_idx_d;
      bus.op_done         <= done_d;
      bus.busy            <= busy_d;
    end
  end

  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_online_op_sequencer.sv
// Directed bench for online_op_sequencer: one instance with NUM_DIGITS=4,
// ONLINE_DELAY=2 and one with ONLINE_DELAY=0. Each scenario drives a per-cycle
// stimulus table and compares every output against a hand-derived timeline.
module tb_online_op_sequencer;

  localparam int NUM_DIGITS = 4;

  logic clk;
  logic reset;
  logic sync0, abort0;
  logic sync1, abort1;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int st, iv, ii, ov, oi, dn, bz, orun;
  } exp_t;

  typedef struct {
    int dut;       // 0: delay 2, 1: delay 0
    int dly;
    int s1;        // cycle of first op_start
    int cut1;      // outputs of first op forced low from this cycle
    int s2;        // cycle of second op_start, -1 if none
    int orun_lo;   // overrun high in [orun_lo, orun_hi)
    int orun_hi;
    int last;
  } scn_t;

  online_op_sequencer_if #(.IDX_W(2)) bus0 ();
  online_op_sequencer_if #(.IDX_W(2)) bus1 ();

  assign bus0.sync_in   = sync0;
  assign bus0.abort_req = abort0;
  assign bus1.sync_in   = sync1;
  assign bus1.abort_req = abort1;

  online_op_sequencer #(.NUM_DIGITS(NUM_DIGITS), .ONLINE_DELAY(2)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  online_op_sequencer #(.NUM_DIGITS(NUM_DIGITS), .ONLINE_DELAY(0)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // timeline of one operation starting at s, truncated at cut
  function automatic exp_t exp_op(input int c, input int s, input int d, input int cut);
    exp_t e = '{default: 0};
    if (s < 0 || c < s || c >= cut || c > s + NUM_DIGITS + d) return e;
    e.st = (c == s) ? 1 : 0;
    if (c < s + NUM_DIGITS) begin
      e.iv = 1;
      e.ii = c - s;
    end
    if (c >= s + d && c < s + d + NUM_DIGITS) begin
      e.ov = 1;
      e.oi = c - s - d;
    end
    e.dn = (c == s + NUM_DIGITS + d) ? 1 : 0;
    e.bz = 1;
    return e;
  endfunction

  // {reset, sync, abort} for scenario id at cycle c
  function automatic logic [2:0] stim(input int id, input int c);
    logic r, s, a;
    r = (c < 2) || (id == 4 && c == 15);
    a = (id == 3 && c == 13);
    case (id)
      1:       s = (c >= 10 && c <= 22);
      2:       s = (c == 10) || (c >= 13);
      3:       s = (c == 10) || (c == 22);
      4:       s = (c == 10) || (c >= 12 && c <= 14);
      5:       s = (c == 10);
      default: s = (c >= 10 && c <= 15) || (c >= 20);
    endcase
    return {r, s, a};
  endfunction

  task automatic run_scn(input int id, input scn_t p);
    logic [2:0] in_v;
    exp_t a, b, e;
    int   g_st, g_iv, g_ii, g_ov, g_oi, g_dn, g_bz, g_or;
    for (int c = 0; c <= p.last; c++) begin
      @(posedge clk);
      #1;
      in_v   = stim(id, c);
      reset  = in_v[2];
      sync0  = (p.dut == 0) ? in_v[1] : 1'b0;
      abort0 = (p.dut == 0) ? in_v[0] : 1'b0;
      sync1  = (p.dut == 1) ? in_v[1] : 1'b0;
      abort1 = (p.dut == 1) ? in_v[0] : 1'b0;
      @(negedge clk);
      if (c < 2) continue;
      a = exp_op(c, p.s1, p.dly, p.cut1);
      b = exp_op(c, p.s2, p.dly, 1 << 20);
      e.st = a.st | b.st;  e.iv = a.iv | b.iv;  e.ii = a.ii + b.ii;
      e.ov = a.ov | b.ov;  e.oi = a.oi + b.oi;  e.dn = a.dn | b.dn;
      e.bz = a.bz | b.bz;
      e.orun = (c >= p.orun_lo && c < p.orun_hi) ? 1 : 0;
      if (p.dut == 0) begin
        g_st = int'(bus0.op_start);        g_iv = int'(bus0.digit_in_valid);
        g_ii = int'(bus0.in_idx);          g_ov = int'(bus0.digit_out_valid);
        g_oi = int'(bus0.out_idx);         g_dn = int'(bus0.op_done);
        g_bz = int'(bus0.busy);            g_or = int'(bus0.overrun);
      end else begin
        g_st = int'(bus1.op_start);        g_iv = int'(bus1.digit_in_valid);
        g_ii = int'(bus1.in_idx);          g_ov = int'(bus1.digit_out_valid);
        g_oi = int'(bus1.out_idx);         g_dn = int'(bus1.op_done);
        g_bz = int'(bus1.busy);            g_or = int'(bus1.overrun);
      end
      check($sformatf("s%0d c%0d op_start", id, c),        g_st, e.st);
      check($sformatf("s%0d c%0d digit_in_valid", id, c),  g_iv, e.iv);
      check($sformatf("s%0d c%0d in_idx", id, c),          g_ii, e.ii);
      check($sformatf("s%0d c%0d digit_out_valid", id, c), g_ov, e.ov);
      check($sformatf("s%0d c%0d out_idx", id, c),         g_oi, e.oi);
      check($sformatf("s%0d c%0d op_done", id, c),         g_dn, e.dn);
      check($sformatf("s%0d c%0d busy", id, c),            g_bz, e.bz);
      check($sformatf("s%0d c%0d overrun", id, c),         g_or, e.orun);
    end
  endtask

  localparam int NEVER = 1 << 20;

  initial begin
    scn_t tbl[6];
    reset  = 1'b1;
    sync0  = 1'b0;
    abort0 = 1'b0;
    sync1  = 1'b0;
    abort1 = 1'b0;
    // held-high trigger: one op, then WAIT_LOW
    tbl[0] = '{dut: 0, dly: 2, s1: 11, cut1: NEVER, s2: -1, orun_lo: NEVER, orun_hi: NEVER, last: 26};
    // re-trigger while running sets overrun from 14
    tbl[1] = '{dut: 0, dly: 2, s1: 11, cut1: NEVER, s2: -1, orun_lo: 14, orun_hi: NEVER, last: 20};
    // abort at 13, clean restart from trigger at 22
    tbl[2] = '{dut: 0, dly: 2, s1: 11, cut1: 14, s2: 23, orun_lo: NEVER, orun_hi: NEVER, last: 27};
    // overrun at 13, reset at 15 clears everything at 16
    tbl[3] = '{dut: 0, dly: 2, s1: 11, cut1: 16, s2: -1, orun_lo: 13, orun_hi: 16, last: 20};
    // zero online delay: in/out strobes coincide, done at 15
    tbl[4] = '{dut: 1, dly: 0, s1: 11, cut1: NEVER, s2: -1, orun_lo: NEVER, orun_hi: NEVER, last: 18};
    // back-to-back: low at 16, high at 20, second start at 21
    tbl[5] = '{dut: 0, dly: 2, s1: 11, cut1: NEVER, s2: 21, orun_lo: NEVER, orun_hi: NEVER, last: 30};
    for (int i = 0; i < 6; i++) run_scn(i + 1, tbl[i]);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
